// File: rtl/fifo_pkg.sv
//----------------------------------------------------------------------------
// fifo_pkg : shared types and width helpers for the FIFO-side blocks
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FILL  = 1'b1
  } acc_state_e;

  // Bits needed to index n items; never below 1 so ports stay legal.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold values 0..max_val; never below 1.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_out_reg.sv
//----------------------------------------------------------------------------
// fifo_wr_out_reg : one-entry output register feeding the FIFO write port
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module fifo_wr_out_reg
  import fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
) (
  input  logic              wr_clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic              last_i,
  input  logic              full_i,
  output logic              wr_en_o,
  output logic              slot_free_o,
  output logic [DATA_W-1:0] data_o,
  output logic [KEEP_W-1:0] keep_o,
  output logic              last_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic              last_q, last_d;

  // A load is only issued when the slot is empty or popping this cycle.
  assign wr_en_o     = valid_q && !full_i;
  assign slot_free_o = !valid_q || !full_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      keep_d  = keep_i;
      last_d  = last_i;
    end else if (wr_en_o) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign data_o = data_q;
  assign keep_o = keep_q;
  assign last_o = last_q;

endmodule

`default_nettype wire

// File: rtl/fifo_wr_packer.sv
//----------------------------------------------------------------------------
// fifo_wr_packer : packs narrow stream beats into wide FIFO words
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module fifo_wr_packer
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int PACK_RATIO = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                           wr_clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [IN_WIDTH-1:0]            s_data,
  input  logic                           s_last,
  input  logic                           fifo_full,
  output logic                           fifo_wr_en,
  output logic [IN_WIDTH*PACK_RATIO-1:0] fifo_din,
  output logic [PACK_RATIO-1:0]          fifo_keep,
  output logic                           fifo_last,
  output logic [15:0]                    words_written
);

  localparam int OUT_WIDTH = IN_WIDTH * PACK_RATIO;
  localparam int LANE_W    = idx_width(PACK_RATIO);
  localparam int TMR_W     = cnt_width(TIMEOUT);

  acc_state_e            state_q, state_d;
  logic [OUT_WIDTH-1:0]  acc_data_q, acc_data_d;
  logic [PACK_RATIO-1:0] acc_keep_q, acc_keep_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [15:0]           words_q;

  logic                  accept;
  logic                  slot_free;
  logic                  load;
  logic                  load_last;
  logic [OUT_WIDTH-1:0]  merged_data;
  logic [PACK_RATIO-1:0] merged_keep;

  assign s_ready = slot_free;
  assign accept  = s_valid && s_ready;

  // Accumulator contents with the current beat (if any) dropped into its lane.
  for (genvar l = 0; l < PACK_RATIO; l++) begin : g_lane
    logic hit;
    assign hit = accept && (lane_q == LANE_W'(l));
    assign merged_data[l*IN_WIDTH +: IN_WIDTH] =
      hit ? s_data : acc_data_q[l*IN_WIDTH +: IN_WIDTH];
    assign merged_keep[l] = hit | acc_keep_q[l];
  end

  always_comb begin
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    lane_d     = lane_q;
    tmr_d      = tmr_q;
    load       = 1'b0;
    load_last  = 1'b0;
    if (accept) begin
      tmr_d = '0;
      if (lane_q == LANE_W'(PACK_RATIO - 1) || s_last) begin
        load       = 1'b1;
        load_last  = s_last;
        acc_data_d = '0;
        acc_keep_d = '0;
        lane_d     = '0;
      end else begin
        acc_data_d = merged_data;
        acc_keep_d = merged_keep;
        lane_d     = lane_q + LANE_W'(1);
      end
    end else if (state_q == ST_FILL && TIMEOUT != 0) begin
      // Saturate at TIMEOUT and wait there until the output slot opens.
      if (tmr_q == TMR_W'(TIMEOUT)) begin
        if (slot_free) begin
          load       = 1'b1;
          acc_data_d = '0;
          acc_keep_d = '0;
          lane_d     = '0;
          tmr_d      = '0;
        end
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end else begin
      tmr_d = '0;
    end
    state_d = (acc_keep_d != '0) ? ST_FILL : ST_EMPTY;
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      acc_data_q <= '0;
      acc_keep_q <= '0;
      lane_q     <= '0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_data_q <= acc_data_d;
      acc_keep_q <= acc_keep_d;
      lane_q     <= lane_d;
      tmr_q      <= tmr_d;
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
    end else if (fifo_wr_en) begin
      words_q <= words_q + 16'd1;
    end
  end

  assign words_written = words_q;

  fifo_wr_out_reg #(
    .DATA_W (OUT_WIDTH),
    .KEEP_W (PACK_RATIO)
  ) u_out_reg (
    .wr_clk      (wr_clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .data_i      (merged_data),
    .keep_i      (merged_keep),
    .last_i      (load_last),
    .full_i      (fifo_full),
    .wr_en_o     (fifo_wr_en),
    .slot_free_o (slot_free),
    .data_o      (fifo_din),
    .keep_o      (fifo_keep),
    .last_o      (fifo_last)
  );

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_packer.sv
//----------------------------------------------------------------------------
// tb_fifo_wr_packer : scoreboard bench for fifo_wr_packer
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_wr_packer;

  localparam int IW = 8;
  localparam int PR = 4;
  localparam int TO = 8;

  typedef struct packed {
    logic [31:0] din;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic        wr_clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [31:0] fifo_din;
  logic [3:0]  fifo_keep;
  logic        fifo_last;
  logic [15:0] words_written;

  int n_chk  = 0;
  int n_fail = 0;

  word_t       exp_q[$];
  logic [7:0]  part[$];
  int          idle_cnt;
  logic [15:0] exp_cnt = '0;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_packer #(.IN_WIDTH(IW), .PACK_RATIO(PR), .TIMEOUT(TO)) dut (
    .wr_clk        (wr_clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .fifo_full     (fifo_full),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_din      (fifo_din),
    .fifo_keep     (fifo_keep),
    .fifo_last     (fifo_last),
    .words_written (words_written)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: beats queue up per word; a word leaves on PR beats, on last,
  // or once the partial has sat idle past TO cycles and the output can take it.
  task automatic emit(input logic lst);
    word_t w;
    w.din  = '0;
    w.keep = '0;
    w.last = lst;
    foreach (part[i]) begin
      w.din[i*8 +: 8] = part[i];
      w.keep[i]       = 1'b1;
    end
    exp_q.push_back(w);
    part.delete();
  endtask

  task automatic model_reset();
    part.delete();
    exp_q.delete();
    idle_cnt = 0;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic f);
    s_valid   = v;
    s_data    = d;
    s_last    = l;
    fifo_full = f;
    @(negedge wr_clk);
    if (s_valid && s_ready) begin
      part.push_back(s_data);
      idle_cnt = 0;
      if (part.size() == PR || s_last) emit(s_last);
    end else if (part.size() != 0) begin
      if (idle_cnt == TO && s_ready) begin
        emit(1'b0);
        idle_cnt = 0;
      end else if (idle_cnt < TO) begin
        idle_cnt++;
      end
    end
    @(posedge wr_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    @(posedge wr_clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every FIFO write must match the oldest expected word.
  always @(negedge wr_clk) begin
    word_t w;
    if (!rst_n) begin
      exp_cnt = '0;
    end else begin
      check("words_written", words_written, exp_cnt);
      if (fifo_wr_en) begin
        exp_cnt = exp_cnt + 16'd1;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          w = exp_q.pop_front();
          check("din", fifo_din, w.din);
          check("keep", fifo_keep, w.keep);
          check("last", fifo_last, w.last);
        end
      end
    end
  end

  initial begin
    logic [31:0] held;
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; fifo_full = 1'b0;
    model_reset();
    repeat (3) @(posedge wr_clk);
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_din", fifo_din, 0);
    check("rst_keep", fifo_keep, 0);
    check("rst_last", fifo_last, 0);
    check("rst_words", words_written, 0);
    rst_n = 1'b1;
    @(posedge wr_clk);
    #1;

    // Full word, one-cycle latency to the write strobe
    cycle(1, 8'h11, 0, 0); cycle(1, 8'h22, 0, 0);
    cycle(1, 8'h33, 0, 0); cycle(1, 8'h44, 0, 0);
    check("full_wr_en", fifo_wr_en, 1);
    check("full_din", fifo_din, 32'h44332211);
    check("full_keep", fifo_keep, 4'hF);
    idle(1);
    check("full_words", words_written, 1);

    // Short packet
    cycle(1, 8'hA1, 0, 0); cycle(1, 8'hA2, 1, 0);
    check("pkt_din", fifo_din, 32'h0000A2A1);
    check("pkt_keep", fifo_keep, 4'h3);
    check("pkt_last", fifo_last, 1);
    idle(2);

    // Idle timeout flush
    cycle(1, 8'h55, 0, 0);
    idle(TO);
    check("to_early", fifo_wr_en, 0);
    idle(1);
    check("to_wr_en", fifo_wr_en, 1);
    check("to_din", fifo_din, 32'h00000055);
    check("to_keep", fifo_keep, 4'h1);
    check("to_last", fifo_last, 0);
    idle(2);

    // A beat on the firing cycle wins over the flush
    cycle(1, 8'h66, 0, 0);
    idle(TO);
    cycle(1, 8'h77, 0, 0);
    check("to_append_no_wr", fifo_wr_en, 0);
    idle(TO + 4);

    // Back-pressure from a full FIFO
    cycle(1, 8'h01, 0, 1); cycle(1, 8'h02, 0, 1);
    cycle(1, 8'h03, 0, 1); cycle(1, 8'h04, 0, 1);
    held = fifo_din;
    check("bp_held_din", held, 32'h04030201);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 8'hE0 + 8'(i), 0, 1);
      check("bp_s_ready", s_ready, 0);
      check("bp_wr_en", fifo_wr_en, 0);
      check("bp_din_stable", fifo_din, held);
    end
    for (int i = 0; i < 4; i++) cycle(1, 8'hB0 + 8'(i), 0, 0);
    idle(2);

    // Reset mid-word discards the partial
    cycle(1, 8'hD1, 0, 0); cycle(1, 8'hD2, 0, 0);
    apply_reset();
    check("mid_rst_wr_en", fifo_wr_en, 0);
    check("mid_rst_words", words_written, 0);
    check("mid_rst_keep", fifo_keep, 0);
    for (int i = 0; i < 4; i++) cycle(1, 8'hC0 + 8'(i), 0, 0);
    check("post_rst_din", fifo_din, 32'hC3C2C1C0);
    check("post_rst_keep", fifo_keep, 4'hF);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) idle(TO + 3);
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) == 0);
    end
    idle(TO + 6);
    check("rand_drained", exp_q.size(), 0);

    // Counter wrap after 2^16 writes
    apply_reset();
    for (int i = 0; i < 65536; i++) cycle(1, 8'(i), 1, 0);
    idle(3);
    check("wrap_words", words_written, 0);
    check("wrap_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
